// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and a per-register pending-write
// scoreboard: RAW hazard flags per read port and a WAW-blocking issue handshake.
module regfile_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]       hazard,
    input  logic                    RegWrite,
    input  logic [AW-1:0]           wa,
    input  logic [WIDTH-1:0]        WD,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic                    flush,
    output logic [AW:0]             busy_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            pend;
    logic [DEPTH-1:0]            pend_nxt;
    logic [AW:0]                 cnt_nxt;

    logic wa_in_rng, ird_in_rng, wr_en, accept;

    assign wa_in_rng  = {1'b0, wa} < DEPTH_W;
    assign ird_in_rng = {1'b0, issue_rd} < DEPTH_W;
    assign wr_en      = RegWrite && (wa != '0) && wa_in_rng;

    // A same-cycle writeback to the reserved register frees the slot for the new owner.
    assign issue_ready = !flush && ((issue_rd == '0) || !ird_in_rng || !pend[issue_rd] ||
                                    (RegWrite && (wa == issue_rd)));
    assign accept = issue_valid && issue_ready && (issue_rd != '0) && ird_in_rng;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          in_rng;
        logic          byp;
        assign a      = ra[i*AW +: AW];
        assign in_rng = {1'b0, a} < DEPTH_W;
        assign byp    = RegWrite && (wa == a) && (a != '0);
        assign rd[i*WIDTH +: WIDTH] = !in_rng ? '0 : (byp ? WD : regs[a]);
        assign hazard[i] = in_rng && (a != '0) && pend[a] && !byp;
    end

    // Reservation is applied after the writeback clear so a collision leaves pend set.
    always_comb begin
        pend_nxt = pend;
        if (wr_en)  pend_nxt[wa] = 1'b0;
        if (accept) pend_nxt[issue_rd] = 1'b1;
        if (flush)  pend_nxt = '0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int j = 0; j < DEPTH; j++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en) regs[wa] <= WD;
            pend     <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, x0, bypass/RAW, WAW handshake, flush, async reset.
module tb_regfile_scoreboard;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                    clk, rst_n;
    logic [NUM_RD*AW-1:0]    ra;
    logic [NUM_RD*WIDTH-1:0] rd;
    logic [NUM_RD-1:0]       hazard;
    logic                    RegWrite;
    logic [AW-1:0]           wa;
    logic [WIDTH-1:0]        WD;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd;
    logic                    issue_ready;
    logic                    flush;
    logic [AW:0]             busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .hazard(hazard),
        .RegWrite(RegWrite), .wa(wa), .WD(WD),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; wa = '0; WD = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
        set_ra(5'd5, 5'd0);
        #2;
        chk("rst_rd", 64'(rd), 64'h0);
        chk("rst_hazard", 64'(hazard), 64'h0);
        chk("rst_busy", 64'(busy_cnt), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);

        // release between edges, write x5 with bypass visible immediately
        #1 rst_n = 1'b1;
        RegWrite = 1'b1; wa = 5'd5; WD = 32'hDEADBEEF;
        #1 chk("byp_x5", 64'(rd[31:0]), 64'hDEADBEEF);
        tick();
        RegWrite = 1'b0; WD = '0;
        #1 chk("arr_x5", 64'(rd[31:0]), 64'hDEADBEEF);

        // x0 protection
        RegWrite = 1'b1; wa = 5'd0; WD = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        set_ra(5'd0, 5'd5);
        #1 chk("x0_ready", 64'(issue_ready), 64'h1);
        chk("x0_byp", 64'(rd[31:0]), 64'h0);
        tick();
        RegWrite = 1'b0; issue_valid = 1'b0;
        #1 chk("x0_rd", 64'(rd[31:0]), 64'h0);
        chk("x0_busy", 64'(busy_cnt), 64'h0);
        chk("x0_hazard", 64'(hazard), 64'h0);

        // RAW: issue x7 then write it back
        issue_valid = 1'b1; issue_rd = 5'd7; set_ra(5'd7, 5'd0);
        #1 chk("raw_pre_haz", 64'(hazard[0]), 64'h0);
        tick();
        issue_valid = 1'b0;
        #1 chk("raw_haz", 64'(hazard[0]), 64'h1);
        chk("raw_busy1", 64'(busy_cnt), 64'h1);
        RegWrite = 1'b1; wa = 5'd7; WD = 32'h1234;
        #1 chk("raw_byp_rd", 64'(rd[31:0]), 64'h1234);
        chk("raw_byp_haz", 64'(hazard[0]), 64'h0);
        chk("raw_busy_m", 64'(busy_cnt), 64'h1);
        tick();
        RegWrite = 1'b0;
        #1 chk("raw_busy0", 64'(busy_cnt), 64'h0);
        chk("raw_haz_clr", 64'(hazard[0]), 64'h0);
        chk("raw_rd", 64'(rd[31:0]), 64'h1234);

        // WAW: x9 pending blocks a second reservation unless written back
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        #1 chk("waw_ready0", 64'(issue_ready), 64'h0);
        tick();
        #1 chk("waw_busy_hold", 64'(busy_cnt), 64'h1);
        RegWrite = 1'b1; wa = 5'd9; WD = 32'h99;
        #1 chk("waw_ready1", 64'(issue_ready), 64'h1);
        tick();
        RegWrite = 1'b0; issue_valid = 1'b0; set_ra(5'd9, 5'd0);
        #1 chk("waw_haz", 64'(hazard[0]), 64'h1);
        chk("waw_busy", 64'(busy_cnt), 64'h1);
        chk("waw_rd", 64'(rd[31:0]), 64'h99);

        // clear x9, then reserve x1..x3 and flush
        RegWrite = 1'b1; wa = 5'd9; WD = 32'h9;
        tick();
        RegWrite = 1'b0;
        issue_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            issue_rd = AW'(r);
            tick();
        end
        issue_valid = 1'b0;
        set_ra(5'd1, 5'd2);
        #1 chk("fl_busy3", 64'(busy_cnt), 64'h3);
        chk("fl_haz_pre", 64'(hazard), 64'h3);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        #1 chk("fl_ready", 64'(issue_ready), 64'h0);
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        #1 chk("fl_busy0", 64'(busy_cnt), 64'h0);
        chk("fl_haz", 64'(hazard), 64'h0);
        set_ra(5'd3, 5'd4);
        #1 chk("fl_haz_x4", 64'(hazard), 64'h0);
        issue_rd = 5'd4;
        #1 chk("fl_ready_x4", 64'(issue_ready), 64'h1);

        // async reset mid-operation
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        RegWrite = 1'b1; wa = 5'd11; WD = 32'hA5A5A5A5;
        tick();
        RegWrite = 1'b0;
        set_ra(5'd11, 5'd10);
        #1 chk("ar_rd_pre", 64'(rd[31:0]), 64'hA5A5A5A5);
        chk("ar_haz_pre", 64'(hazard), 64'h2);
        chk("ar_busy_pre", 64'(busy_cnt), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk("ar_rd", 64'(rd[31:0]), 64'h0);
        chk("ar_haz", 64'(hazard), 64'h0);
        chk("ar_busy", 64'(busy_cnt), 64'h0);
        #2 rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
